// File: rtl/mc_control_p.sv
// mc_control_p: multi-cycle MIPS control FSM with a variable-latency memory
// handshake, stall timeout and sticky fault status.
//
// Optional feature macro: MCCTL_TRAP_EN
//   defined   - illegal instructions and memory timeouts enter TRAP (4'd15),
//               which drives every strobe low and holds until reset.
//   undefined - illegal instructions act as NOPs, a timeout abandons the access
//               and returns to FETCH; illegal_o is tied low.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   ir_i            instruction register contents
//   zero_i          ALU zero flag (branch condition is resolved in the datapath)
//   mem_ready_i     memory completes the current read/write this cycle
//   pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o   PC update control
//   iord_o, mem_read_o, mem_write_o, ir_write_o              memory / IR control
//   reg_dst_o, mem_to_reg_o, reg_write_o                     register file control
//   alu_src_a_o, alu_src_b_o, imm_zext_o, alu_ctrl_o         ALU control
//   state_o         current state (debug)
//   mem_fault_o     sticky memory timeout flag
//   illegal_o       sticky undecodable-instruction flag
module mc_control_p #(
    parameter int unsigned TIMEOUT_W    = 8,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        branch_ne_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic [1:0]  reg_dst_o,
    output logic [1:0]  mem_to_reg_o,
    output logic        reg_write_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic        imm_zext_o,
    output logic [1:0]  pc_source_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [3:0]  state_o,
    output logic        mem_fault_o,
    output logic        illegal_o
);

    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StMemAddr = 4'd2;
    localparam logic [3:0] StMemRd   = 4'd3;
    localparam logic [3:0] StMemWb   = 4'd4;
    localparam logic [3:0] StMemWr   = 4'd5;
    localparam logic [3:0] StRExec   = 4'd6;
    localparam logic [3:0] StRWb     = 4'd7;
    localparam logic [3:0] StBranch  = 4'd8;
    localparam logic [3:0] StJump    = 4'd9;
    localparam logic [3:0] StIExec   = 4'd10;
    localparam logic [3:0] StIWb     = 4'd11;
    localparam logic [3:0] StJal     = 4'd12;
    localparam logic [3:0] StJr      = 4'd13;
`ifdef MCCTL_TRAP_EN
    localparam logic [3:0] StTrap    = 4'd15;
    localparam logic [3:0] StFault   = StTrap;
`else
    // Faults fall back to FETCH: illegal op becomes a NOP, timeout retries.
    localparam logic [3:0] StFault   = StFetch;
`endif

    localparam logic [5:0] OpRtype = 6'h00, OpJ    = 6'h02, OpJal  = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04, OpBne  = 6'h05, OpAddi = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09, OpSlti = 6'h0a, OpAndi = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d, OpLui  = 6'h0f, OpLw   = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b, FnJr   = 6'h08;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr   = 4'd3;
    localparam logic [3:0] AluSlt = 4'd4, AluXor = 4'd5, AluNor = 4'd6, AluSltu = 4'd7;
    localparam logic [3:0] AluLui = 4'd8;

    logic [3:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] stall_q, stall_d;
    logic                 fault_q;
    logic                 waiting, timeout, illegal_hit;
    logic [5:0]           opcode, funct;
    logic                 r_legal, i_zext;
    logic [3:0]           r_alu, i_alu;
    logic                 pc_write_c, pc_write_cond_c, ir_write_c, reg_write_c, mem_write_c;
    logic                 unused_inputs;

    assign opcode        = ir_i[31:26];
    assign funct         = ir_i[5:0];
    assign unused_inputs = ^{zero_i, ir_i[25:6]};

    always_comb begin
        r_legal = 1'b1;
        r_alu   = AluAdd;
        case (funct)
            6'h20, 6'h21: r_alu = AluAdd;
            6'h22, 6'h23: r_alu = AluSub;
            6'h24:        r_alu = AluAnd;
            6'h25:        r_alu = AluOr;
            6'h26:        r_alu = AluXor;
            6'h27:        r_alu = AluNor;
            6'h2a:        r_alu = AluSlt;
            6'h2b:        r_alu = AluSltu;
            default:      r_legal = 1'b0;
        endcase
    end

    always_comb begin
        i_alu  = AluAdd;
        i_zext = 1'b0;
        case (opcode)
            OpSlti:  i_alu = AluSlt;
            OpAndi:  begin i_alu = AluAnd; i_zext = 1'b1; end
            OpOri:   begin i_alu = AluOr;  i_zext = 1'b1; end
            OpLui:   begin i_alu = AluLui; i_zext = 1'b1; end
            default: i_alu = AluAdd;
        endcase
    end

    // A ready arriving in the expiry cycle completes the access instead of faulting.
    assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout = waiting && !mem_ready_i && (WAIT_TIMEOUT != 0)
                     && (stall_q == TIMEOUT_W'(WAIT_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        illegal_hit = 1'b0;
        case (state_q)
            StFetch:   if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpRtype:                                      state_d = (funct == FnJr) ? StJr : StRExec;
                    OpLw, OpSw:                                   state_d = StMemAddr;
                    OpBeq, OpBne:                                 state_d = StBranch;
                    OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpLui: state_d = StIExec;
                    OpJ:                                          state_d = StJump;
                    OpJal:                                        state_d = StJal;
                    default:                                      illegal_hit = 1'b1;
                endcase
            end
            StRExec:   if (r_legal) state_d = StRWb; else illegal_hit = 1'b1;
            StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready_i) state_d = StMemWb;
            StMemWr:   if (mem_ready_i) state_d = StFetch;
            StIExec:   state_d = StIWb;
`ifdef MCCTL_TRAP_EN
            StTrap:    state_d = StTrap;
`endif
            default:   state_d = StFetch;
        endcase
        if (illegal_hit || timeout) state_d = StFault;
    end

    // A FETCH retry keeps the same state, so the timeout itself also clears the count.
    always_comb begin
        if ((state_d != state_q) || timeout) begin
            stall_d = '0;
        end else if (waiting && !mem_ready_i) begin
            stall_d = stall_q + TIMEOUT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            stall_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            fault_q <= fault_q | timeout;
        end
    end

`ifdef MCCTL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_q | illegal_hit;
    end
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    always_comb begin
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        mem_write_c     = 1'b0;
        branch_ne_o     = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        reg_dst_o       = 2'b00;
        mem_to_reg_o    = 2'b00;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        imm_zext_o      = 1'b0;
        pc_source_o     = 2'b00;
        alu_ctrl_o      = AluAdd;
        case (state_q)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_c  = mem_ready_i;
                pc_write_c  = mem_ready_i;
            end
            StDecode:  alu_src_b_o = 2'b11;
            StRExec: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = r_alu;
            end
            StRWb: begin
                reg_write_c = 1'b1;
                reg_dst_o   = 2'b01;
            end
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            StMemRd: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
            end
            StMemWr: begin
                iord_o      = 1'b1;
                mem_write_c = 1'b1;
            end
            StMemWb: begin
                reg_write_c  = 1'b1;
                mem_to_reg_o = 2'b01;
            end
            StIExec: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_ctrl_o  = i_alu;
                imm_zext_o  = i_zext;
            end
            StIWb:     reg_write_c = 1'b1;
            StBranch: begin
                alu_src_a_o     = 1'b1;
                alu_ctrl_o      = AluSub;
                pc_write_cond_c = 1'b1;
                pc_source_o     = 2'b01;
                branch_ne_o     = ir_i[26];
            end
            StJump: begin
                pc_write_c  = 1'b1;
                pc_source_o = 2'b10;
            end
            // Link register receives the current PC, already advanced to PC+4 by FETCH.
            StJal: begin
                pc_write_c   = 1'b1;
                pc_source_o  = 2'b10;
                reg_write_c  = 1'b1;
                reg_dst_o    = 2'b10;
                mem_to_reg_o = 2'b10;
            end
            StJr: begin
                pc_write_c  = 1'b1;
                pc_source_o = 2'b11;
            end
            default: ;
        endcase
    end

    // Architectural strobes are held low for the whole reset pulse.
    assign pc_write_o      = pc_write_c & ~reset;
    assign pc_write_cond_o = pc_write_cond_c & ~reset;
    assign ir_write_o      = ir_write_c & ~reset;
    assign reg_write_o     = reg_write_c & ~reset;
    assign mem_write_o     = mem_write_c & ~reset;
    assign state_o         = state_q;
    assign mem_fault_o     = fault_q;

endmodule

// File: tb/tb_mc_control_p.sv
module tb_mc_control_p;

    localparam int TO = 5;

    typedef struct packed {
        logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_source;
        logic [3:0] alu_ctrl;
        logic       mem_fault, illegal;
    } vec_t;

    logic        clk, reset, zero, mem_ready;
    logic [31:0] ir;
    logic        pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o;
    logic        ir_write_o, reg_write_o, alu_src_a_o, imm_zext_o, mem_fault_o, illegal_o;
    logic [1:0]  reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o;
    logic [3:0]  alu_ctrl_o, state_o;

    mc_control_p #(.TIMEOUT_W(8), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ir_i(ir), .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
        .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .imm_zext_o(imm_zext_o), .pc_source_o(pc_source_o), .alu_ctrl_o(alu_ctrl_o),
        .state_o(state_o), .mem_fault_o(mem_fault_o), .illegal_o(illegal_o)
    );

    vec_t dut_v;
    assign dut_v = {pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o,
                    ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                    imm_zext_o, pc_source_o, alu_ctrl_o, mem_fault_o, illegal_o};

    // Model state: expected vector for the current cycle plus sticky flags.
    vec_t       exp_v;
    logic       exp_valid, exp_schk;
    logic [3:0] exp_st;
    logic       flt, ill;
    int         checks, errors, cyc_cnt, rw_cnt, mr_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            checks = checks + 1;
            if (dut_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL outputs cyc=%0d ir=%h got=%h want=%h", cyc_cnt, ir, dut_v, exp_v);
            end
            if (exp_schk) begin
                checks = checks + 1;
                if (state_o !== exp_st) begin
                    errors = errors + 1;
                    $display("FAIL state cyc=%0d got=%0d want=%0d", cyc_cnt, state_o, exp_st);
                end
            end
            if (reg_write_o) rw_cnt = rw_cnt + 1;
            if (mem_read_o)  mr_cnt = mr_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // One cycle: drive inputs, publish expectation, advance to just after the next edge.
    task automatic step(input vec_t v, input logic schk, input logic [3:0] st,
                        input logic rdy, input logic z);
        v.mem_fault = flt;
        v.illegal   = ill;
        mem_ready   = rdy;
        zero        = z;
        exp_v       = v;
        exp_schk    = schk;
        exp_st      = st;
        exp_valid   = 1'b1;
        @(posedge clk);
        #1;
        cyc_cnt = cyc_cnt + 1;
    endtask

    task automatic fault_path();
`ifdef MCCTL_TRAP_EN
        vec_t v;
        v = '0;
        for (int i = 0; i < 3; i++) step(v, 1'b1, 4'd15, 1'b1, 1'b0);
`endif
    endtask

    task automatic illegal_path();
`ifdef MCCTL_TRAP_EN
        ill = 1'b1;
`endif
        fault_path();
    endtask

    // kind 0 = instruction fetch, 1 = data read, 2 = data write; ready after `waits` stalls.
    task automatic mem_phase(input int kind, input int waits, output logic to);
        vec_t v;
        logic rdy, tmo;
        to = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            rdy = (k == waits);
            v   = '0;
            case (kind)
                0: begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
                1: begin v.iord = 1; v.mem_read = 1; end
                default: begin v.iord = 1; v.mem_write = 1; end
            endcase
            tmo = !rdy && (TO != 0) && (k == TO);
            step(v, kind == 0, 4'd0, rdy, 1'b0);
            if (tmo) begin
                flt = 1'b1;
                to  = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [4:0] r_op(input logic [5:0] fn);  // {legal, alu op}
        case (fn)
            6'h20, 6'h21: return 5'h10;
            6'h22, 6'h23: return 5'h11;
            6'h24:        return 5'h12;
            6'h25:        return 5'h13;
            6'h26:        return 5'h15;
            6'h27:        return 5'h16;
            6'h2a:        return 5'h14;
            6'h2b:        return 5'h17;
            default:      return 5'h00;
        endcase
    endfunction

    function automatic logic [4:0] i_op(input logic [5:0] op);  // {zext, alu op}
        case (op)
            6'h0a:   return 5'h04;
            6'h0c:   return 5'h12;
            6'h0d:   return 5'h13;
            6'h0f:   return 5'h18;
            default: return 5'h00;
        endcase
    endfunction

    // Walks one instruction through the cycles its class must take.
    task automatic exec(input logic [31:0] ins, input logic z, input int fw, input int mw,
                        output int cyc);
        vec_t       v;
        logic       to;
        int         c0;
        logic [5:0] op, fn;
        logic [4:0] ro;
        c0 = cyc_cnt;
        ir = ins;
        op = ins[31:26];
        fn = ins[5:0];
        mem_phase(0, fw, to);
        if (to) begin
            fault_path();
        end else begin
            v = '0; v.alu_src_b = 2'b11;
            step(v, 1'b1, 4'd1, 1'b0, z);
            v = '0;
            if (op == 6'h00 && fn == 6'h08) begin
                v.pc_write = 1; v.pc_source = 2'b11;
                step(v, 1'b0, 4'd0, 1'b0, z);
            end else begin
                case (op)
                    6'h00: begin
                        ro = r_op(fn);
                        v.alu_src_a = 1; v.alu_ctrl = ro[3:0];
                        step(v, 1'b0, 4'd0, 1'b0, z);
                        if (ro[4]) begin
                            v = '0; v.reg_write = 1; v.reg_dst = 2'b01;
                            step(v, 1'b0, 4'd0, 1'b0, z);
                        end else begin
                            illegal_path();
                        end
                    end
                    6'h23, 6'h2b: begin
                        v.alu_src_a = 1; v.alu_src_b = 2'b10;
                        step(v, 1'b0, 4'd0, 1'b0, z);
                        mem_phase((op == 6'h2b) ? 2 : 1, mw, to);
                        if (to) begin
                            fault_path();
                        end else if (op == 6'h23) begin
                            v = '0; v.reg_write = 1; v.mem_to_reg = 2'b01;
                            step(v, 1'b0, 4'd0, 1'b0, z);
                        end
                    end
                    6'h04, 6'h05: begin
                        v.alu_src_a = 1; v.alu_ctrl = 4'd1; v.pc_write_cond = 1;
                        v.pc_source = 2'b01; v.branch_ne = op[0];
                        step(v, 1'b0, 4'd0, 1'b0, z);
                    end
                    6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f: begin
                        ro = i_op(op);
                        v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_ctrl = ro[3:0];
                        v.imm_zext = ro[4];
                        step(v, 1'b0, 4'd0, 1'b0, z);
                        v = '0; v.reg_write = 1;
                        step(v, 1'b0, 4'd0, 1'b0, z);
                    end
                    6'h02: begin
                        v.pc_write = 1; v.pc_source = 2'b10;
                        step(v, 1'b0, 4'd0, 1'b0, z);
                    end
                    6'h03: begin
                        v.pc_write = 1; v.pc_source = 2'b10; v.reg_write = 1;
                        v.reg_dst = 2'b10; v.mem_to_reg = 2'b10;
                        step(v, 1'b0, 4'd0, 1'b0, z);
                    end
                    default: illegal_path();
                endcase
            end
        end
        cyc = cyc_cnt - c0;
    endtask

    task automatic reset_pulse(input string nm);
        exp_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk({nm, " state"}, {28'h0, state_o}, 32'h0);
        chk({nm, " mem_fault"}, {31'h0, mem_fault_o}, 32'h0);
        chk({nm, " illegal"}, {31'h0, illegal_o}, 32'h0);
        chk({nm, " mem_write"}, {31'h0, mem_write_o}, 32'h0);
        flt       = 1'b0;
        ill       = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic recover();
`ifdef MCCTL_TRAP_EN
        reset_pulse("trap reset");
`endif
    endtask

    initial begin
        int   c;
        vec_t v;
        logic to;
        checks = 0; errors = 0; cyc_cnt = 0; rw_cnt = 0; mr_cnt = 0;
        exp_valid = 1'b0; exp_schk = 1'b0; exp_st = 4'd0; exp_v = '0;
        flt = 1'b0; ill = 1'b0;
        reset = 1'b1; ir = 32'h0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        // FETCH with ready high must still show no strobes while reset is held.
        chk("reset pc_write", {31'h0, pc_write_o}, 32'h0);
        chk("reset ir_write", {31'h0, ir_write_o}, 32'h0);
        chk("reset mem_read", {31'h0, mem_read_o}, 32'h1);
        reset_pulse("reset");

        exec(32'h00221820, 1'b0, 0, 0, c); chk("add latency", c, 4);
        exec(32'h00221822, 1'b0, 0, 0, c); chk("sub latency", c, 4);
        exec(32'h00221827, 1'b0, 1, 0, c); chk("nor 1-wait latency", c, 5);
        rw_cnt = 0; mr_cnt = 0;
        exec(32'h8c220004, 1'b0, 0, 3, c); chk("lw 3-wait latency", c, 8);
        chk("lw reg_write count", rw_cnt, 1);
        chk("lw mem_read count", mr_cnt, 5);
        exec(32'h14220003, 1'b0, 0, 0, c); chk("bne latency", c, 3);
        exec(32'h10220003, 1'b1, 0, 0, c); chk("beq latency", c, 3);
        exec(32'h0c000010, 1'b0, 0, 0, c); chk("jal latency", c, 3);
        exec(32'h03e00008, 1'b0, 0, 0, c); chk("jr latency", c, 3);
        exec(32'h08000010, 1'b0, 0, 0, c); chk("j latency", c, 3);
        exec(32'h34220005, 1'b0, 0, 0, c); chk("ori latency", c, 4);
        exec(32'h28220005, 1'b0, 0, 0, c);
        exec(32'h3c011234, 1'b0, 0, 0, c);
        exec(32'hac220004, 1'b0, 0, 2, c); chk("sw 2-wait latency", c, 6);

        // Ready just before and exactly at expiry: both complete without a fault.
        exec(32'h00221820, 1'b0, TO - 1, 0, c);
        exec(32'h00221820, 1'b0, TO, 0, c); chk("expiry tie latency", c, 4 + TO);
        chk("expiry tie mem_fault", {31'h0, mem_fault_o}, 32'h0);

        exec(32'hfc000000, 1'b0, 0, 0, c);
`ifdef MCCTL_TRAP_EN
        chk("illegal opcode flag", {31'h0, illegal_o}, 32'h1);
`else
        chk("illegal opcode nop latency", c, 2);
`endif
        recover();
        exec(32'h0000003f, 1'b0, 0, 0, c);
        recover();

        exec(32'h00221820, 1'b0, 100, 0, c);
        chk("fetch timeout mem_fault", {31'h0, mem_fault_o}, 32'h1);
        recover();
        exec(32'h00221820, 1'b0, 2, 0, c);
        exec(32'h8c220004, 1'b0, 0, 100, c);
        recover();
        exec(32'h00221820, 1'b0, 0, 0, c); chk("post-timeout add latency", c, 4);

        // Reset arriving mid-store must drop mem_write without waiting for a clock edge.
        ir = 32'hac220004;
        mem_phase(0, 0, to);
        v = '0; v.alu_src_b = 2'b11;
        step(v, 1'b1, 4'd1, 1'b0, 1'b0);
        v = '0; v.alu_src_a = 1; v.alu_src_b = 2'b10;
        step(v, 1'b0, 4'd0, 1'b0, 1'b0);
        v = '0; v.iord = 1; v.mem_write = 1;
        step(v, 1'b0, 4'd0, 1'b0, 1'b0);
        exp_valid = 1'b0;
        mem_ready = 1'b0;
        #2;
        chk("mid-store mem_write before reset", {31'h0, mem_write_o}, 32'h1);
        reset_pulse("mid-store reset");
        exec(32'h00221820, 1'b0, 0, 0, c); chk("add after reset latency", c, 4);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
